// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID pipeline register with RV32I decode, stall, flush and post-redirect kill window
module if_id_decode #(
  parameter int          FLUSH_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] pc_out,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [1:0] KILL_INIT = 2'(FLUSH_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Pipeline state: the captured word, its PC, liveness and the stale-slot kill counter
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [1:0]  kill_q, kill_d;

  // Shared ALU mapping for OP and OP-IMM; bit 30 only selects SUB when the caller allows it
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic b30,
                                                 input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (b30 && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Next-state selection: flush beats stall beats load; tick=0 freezes everything
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    if (tick) begin
      if (flush) begin
        valid_d = 1'b0;
        kill_d  = KILL_INIT;
      end else if (stall) begin
        valid_d = valid_q;
      end else if (kill_q != 2'd0) begin
        valid_d = 1'b0;
        kill_d  = kill_q - 2'd1;
      end else begin
        valid_d = 1'b1;
        instr_d = instr_in;
        pc_d    = pc_in;
      end
    end
  end

  // State registers with synchronous reset to an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= 32'h0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      kill_q  <= 2'd0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
    end
  end

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_q[6:0];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  logic [31:0] imm_c;
  logic [3:0]  alu_op_c;
  logic        src_imm_c, we_c, re_c, mwe_c, br_c, jmp_c, ill_c;

  // Decode of the registered word; illegal encodings leave every enable low
  always_comb begin
    imm_c     = 32'h0;
    alu_op_c  = ALU_ADD;
    src_imm_c = 1'b0;
    we_c      = 1'b0;
    re_c      = 1'b0;
    mwe_c     = 1'b0;
    br_c      = 1'b0;
    jmp_c     = 1'b0;
    ill_c     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_c = imm_u; alu_op_c = ALU_PASSB; src_imm_c = 1'b1; we_c = 1'b1;
      end
      OPC_AUIPC: begin
        imm_c = imm_u; alu_op_c = ALU_ADD; src_imm_c = 1'b1; we_c = 1'b1;
      end
      OPC_JAL: begin
        imm_c = imm_j; jmp_c = 1'b1; we_c = 1'b1;
      end
      OPC_JALR: begin
        imm_c = imm_i; src_imm_c = 1'b1; jmp_c = 1'b1; we_c = 1'b1;
      end
      OPC_BRANCH: begin
        imm_c = imm_b; alu_op_c = ALU_SUB; br_c = 1'b1;
      end
      OPC_LOAD: begin
        imm_c = imm_i; src_imm_c = 1'b1; re_c = 1'b1; we_c = 1'b1;
      end
      OPC_STORE: begin
        imm_c = imm_s; src_imm_c = 1'b1; mwe_c = 1'b1;
      end
      OPC_OPIMM: begin
        imm_c     = imm_i;
        src_imm_c = 1'b1;
        alu_op_c  = alu_from_funct3(instr_q[14:12], instr_q[30], 1'b0);
        we_c      = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == 7'h00 || funct7 == 7'h20) begin
          alu_op_c = alu_from_funct3(instr_q[14:12], instr_q[30], 1'b1);
          we_c     = 1'b1;
        end else begin
          ill_c = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: begin
        ill_c = 1'b0;
      end
      default: ill_c = 1'b1;
    endcase
  end

  logic [4:0] rd_raw;
  assign rd_raw = instr_q[11:7];

  assign valid       = valid_q;
  assign pc_out      = pc_q;
  assign rd          = valid_q ? rd_raw : 5'd0;
  assign rs1         = valid_q ? instr_q[19:15] : 5'd0;
  assign rs2         = valid_q ? instr_q[24:20] : 5'd0;
  assign funct3      = valid_q ? instr_q[14:12] : 3'd0;
  assign imm         = valid_q ? imm_c : 32'h0;
  assign alu_op      = valid_q ? alu_op_c : ALU_ADD;
  assign alu_src_imm = valid_q & src_imm_c;
  assign reg_we      = valid_q & ~ill_c & we_c & (rd_raw != 5'd0);
  assign mem_re      = valid_q & ~ill_c & re_c;
  assign mem_we      = valid_q & ~ill_c & mwe_c;
  assign branch      = valid_q & ~ill_c & br_c;
  assign jump        = valid_q & ~ill_c & jmp_c;
  assign illegal     = valid_q & ill_c;

endmodule

// File: tb/tb_if_id_decode.sv
// tb/tb_if_id_decode.sv - directed bench for if_id_decode
module tb_if_id_decode;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [31:0] pc_out;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        alu_src_imm, reg_we, mem_re, mem_we, branch, jump, illegal;

  int checks = 0;
  int errors = 0;

  if_id_decode #(.FLUSH_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .instr_in(instr_in), .pc_in(pc_in),
    .stall(stall), .flush(flush), .valid(valid), .pc_out(pc_out), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .funct3(funct3), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enables packed as {reg_we, mem_re, mem_we, branch, jump, illegal}
  logic [5:0] en;
  assign en = {reg_we, mem_re, mem_we, branch, jump, illegal};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w, input logic [31:0] pc);
    instr_in = w;
    pc_in    = pc;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; stall = 1'b0; flush = 1'b0;
    instr_in = 32'h00500093; pc_in = 32'h100;
    step(); step();
    rst = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", valid); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_out); end
    checks++; if (en !== 6'b0) begin errors++; $display("FAIL reset_enables got %b want 000000", en); end
    checks++; if ({rd, imm, alu_op} !== 41'h0) begin errors++; $display("FAIL reset_fields rd=%0d imm=%h alu=%0d want 0", rd, imm, alu_op); end
  endtask

  task automatic test_decode();
    load(32'h00500093, 32'h0);  // addi x1,x0,5
    checks++; if ({valid, rd, rs1, imm, alu_src_imm, reg_we, alu_op, pc_out} !== {1'b1, 5'd1, 5'd0, 32'd5, 1'b1, 1'b1, 4'd0, 32'h0})
      begin errors++; $display("FAIL addi v=%0d rd=%0d rs1=%0d imm=%h src=%0d we=%0d alu=%0d pc=%h", valid, rd, rs1, imm, alu_src_imm, reg_we, alu_op, pc_out); end
    load(32'h0020A423, 32'h4);  // sw x2,8(x1)
    checks++; if ({mem_we, mem_re, rs1, rs2, imm, reg_we, funct3, pc_out} !== {1'b1, 1'b0, 5'd1, 5'd2, 32'd8, 1'b0, 3'd2, 32'h4})
      begin errors++; $display("FAIL sw mwe=%0d mre=%0d rs1=%0d rs2=%0d imm=%h we=%0d f3=%0d pc=%h", mem_we, mem_re, rs1, rs2, imm, reg_we, funct3, pc_out); end
    load(32'hFE000EE3, 32'h8);  // beq x0,x0,-4
    checks++; if ({branch, imm, alu_op, reg_we, jump} !== {1'b1, 32'hFFFFFFFC, 4'd1, 1'b0, 1'b0})
      begin errors++; $display("FAIL beq br=%0d imm=%h alu=%0d we=%0d j=%0d", branch, imm, alu_op, reg_we, jump); end
    load(32'h123452B7, 32'hC);  // lui x5,0x12345
    checks++; if ({imm, rd, alu_op, reg_we, alu_src_imm} !== {32'h12345000, 5'd5, 4'd10, 1'b1, 1'b1})
      begin errors++; $display("FAIL lui imm=%h rd=%0d alu=%0d we=%0d src=%0d", imm, rd, alu_op, reg_we, alu_src_imm); end
    load(32'h402081B3, 32'h10); // sub x3,x1,x2
    checks++; if ({alu_op, alu_src_imm, reg_we, rd, illegal} !== {4'd1, 1'b0, 1'b1, 5'd3, 1'b0})
      begin errors++; $display("FAIL sub alu=%0d src=%0d we=%0d rd=%0d ill=%0d", alu_op, alu_src_imm, reg_we, rd, illegal); end
    load(32'h4030D293, 32'h14); // srai x5,x1,3
    checks++; if ({alu_op, alu_src_imm, rd} !== {4'd7, 1'b1, 5'd5})
      begin errors++; $display("FAIL srai alu=%0d src=%0d rd=%0d", alu_op, alu_src_imm, rd); end
    load(32'h40000093, 32'h18); // addi x1,x0,1024 (bit 30 set)
    checks++; if ({alu_op, imm} !== {4'd0, 32'd1024})
      begin errors++; $display("FAIL addi_b30 alu=%0d imm=%h want alu=0 imm=400", alu_op, imm); end
    load(32'h008000EF, 32'h1C); // jal x1,8
    checks++; if ({jump, reg_we, imm, branch} !== {1'b1, 1'b1, 32'd8, 1'b0})
      begin errors++; $display("FAIL jal j=%0d we=%0d imm=%h br=%0d", jump, reg_we, imm, branch); end
  endtask

  task automatic test_stall();
    load(32'h00700193, 32'h20); // addi x3,x0,7
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load(32'h00A00213 + 32'(i) * 32'h100000, 32'h100 + 32'(i));
      checks++; if ({valid, rd, imm, pc_out} !== {1'b1, 5'd3, 32'd7, 32'h20})
        begin errors++; $display("FAIL stall_hold%0d v=%0d rd=%0d imm=%h pc=%h", i, valid, rd, imm, pc_out); end
    end
    stall = 1'b0;
    load(32'h00A00213, 32'h24); // addi x4,x0,10
    checks++; if ({valid, rd, imm, pc_out} !== {1'b1, 5'd4, 32'd10, 32'h24})
      begin errors++; $display("FAIL stall_release v=%0d rd=%0d imm=%h pc=%h", valid, rd, imm, pc_out); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    load(32'h00500093, 32'h28);
    flush = 1'b0;
    checks++; if ({valid, en} !== 7'b0) begin errors++; $display("FAIL flush_bubble v=%0d en=%b", valid, en); end
    for (int i = 0; i < 2; i++) begin
      load(32'h00500093, 32'h2C + 32'(4 * i));
      checks++; if ({valid, reg_we} !== 2'b0) begin errors++; $display("FAIL flush_kill%0d v=%0d we=%0d", i, valid, reg_we); end
    end
    load(32'h00A00213, 32'h40);
    checks++; if ({valid, rd, pc_out} !== {1'b1, 5'd4, 32'h40})
      begin errors++; $display("FAIL flush_resume v=%0d rd=%0d pc=%h", valid, rd, pc_out); end
  endtask

  task automatic test_flush_stall();
    flush = 1'b1; stall = 1'b1;
    load(32'h00500093, 32'h44);
    flush = 1'b0; stall = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_over_stall v=%0d want 0", valid); end
    load(32'h00500093, 32'h48);  // kill 2 -> 1
    stall = 1'b1;
    load(32'h00500093, 32'h4C);  // held, counter stays 1
    stall = 1'b0;
    load(32'h00500093, 32'h50);  // kill 1 -> 0
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_in_kill v=%0d want 0", valid); end
    load(32'h00500093, 32'h54);
    checks++; if ({valid, pc_out} !== {1'b1, 32'h54}) begin errors++; $display("FAIL flush_stall_resume v=%0d pc=%h", valid, pc_out); end
  endtask

  task automatic test_reflush();
    flush = 1'b1; load(32'h0, 32'h58); flush = 1'b0;
    load(32'h00500093, 32'h5C);  // counter 2 -> 1
    flush = 1'b1; load(32'h0, 32'h60); flush = 1'b0;  // reload to 2
    load(32'h00500093, 32'h64);
    load(32'h00500093, 32'h68);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reflush_reload v=%0d want 0", valid); end
    load(32'h00500093, 32'h6C);
    checks++; if ({valid, pc_out} !== {1'b1, 32'h6C}) begin errors++; $display("FAIL reflush_resume v=%0d pc=%h", valid, pc_out); end
  endtask

  task automatic test_tick_gate();
    tick = 1'b0; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load(32'hFFFFFFFF, 32'h900);
      checks++; if ({valid, rd, imm, pc_out, illegal} !== {1'b1, 5'd1, 32'd5, 32'h6C, 1'b0})
        begin errors++; $display("FAIL tick_hold%0d v=%0d rd=%0d imm=%h pc=%h ill=%0d", i, valid, rd, imm, pc_out, illegal); end
    end
    tick = 1'b1; flush = 1'b0;
  endtask

  task automatic test_illegal();
    load(32'hFFFFFFFF, 32'h70);
    checks++; if ({valid, illegal, reg_we, mem_re, mem_we, branch, jump} !== 7'b1100000)
      begin errors++; $display("FAIL illegal_ones v=%0d en=%b", valid, en); end
    load(32'h022080B3, 32'h74); // mul x1,x1,x2: funct7=0x01
    checks++; if ({valid, illegal, reg_we} !== 3'b110)
      begin errors++; $display("FAIL illegal_funct7 v=%0d ill=%0d we=%0d", valid, illegal, reg_we); end
    load(32'h0000000F, 32'h78); // fence
    checks++; if ({valid, en} !== {1'b1, 6'b0})
      begin errors++; $display("FAIL fence v=%0d en=%b", valid, en); end
  endtask

  task automatic test_x0();
    load(32'h00100013, 32'h7C); // addi x0,x0,1
    checks++; if ({valid, reg_we, illegal, rd} !== {1'b1, 1'b0, 1'b0, 5'd0})
      begin errors++; $display("FAIL x0_we v=%0d we=%0d ill=%0d rd=%0d", valid, reg_we, illegal, rd); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reflush();
    test_tick_gate();
    test_illegal();
    test_x0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
